instr_fetch_unit: RTL

//  Instruction fetch front end: the producer side of the 16-bit instruction-decode interface.

---
 rtl/instr_fetch_unit_if.sv | 35 +++
 rtl/instr_fetch_unit.sv | 111 +++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port, decode valid/ready port and
// the execute-stage redirect inputs. master = fetch unit, slave = its environment.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;

  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] instr_pc;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, imm, instr_pc,
    input  instr_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, imm, instr_pc,
    output instr_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: walks the PC through instruction memory, assembles
// 1- or 2-word instructions and hands them to decode; execute may redirect the PC.
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_unit_if.master    bus,
  output logic [1:0]            state_dbg
);

  // Handshakes: a memory request stays up with a stable address until the cycle
  // imem_ack=1, which completes it with imem_rdata. A decode transfer happens on a
  // cycle where instr_valid & instr_ready; instr/imm/instr_pc hold while valid waits.
  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    ISSUE     = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       imm_q, imm_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

  function automatic logic is_two_word(input logic [4:0] opcode);
    case (opcode)
      5'b00111, 5'b01110, 5'b01111, 5'b10100, 5'b10101: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    instr_pc_d = instr_pc_q;

    // A redirect wins in every state; any same-cycle memory word is dropped.
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      state_d = FETCH_OP;
    end else begin
      case (state_q)
        FETCH_OP: begin
          if (bus.imem_ack) begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            imm_d      = '0;
            pc_d       = pc_q + PC_ONE;
            state_d    = is_two_word(bus.imem_rdata[15:11]) ? FETCH_IMM : ISSUE;
          end
        end
        FETCH_IMM: begin
          if (bus.imem_ack) begin
            imm_d   = bus.imem_rdata;
            pc_d    = pc_q + PC_ONE;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (bus.instr_ready) state_d = FETCH_OP;
        end
        default: state_d = FETCH_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH_OP;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      imm_q      <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Outputs are gated by rst_n so nothing is requested or offered while held in reset.
  always_comb begin
    bus.imem_req    = rst_n & ((state_q == FETCH_OP) | (state_q == FETCH_IMM));
    bus.imem_addr   = pc_q;
    bus.instr_valid = rst_n & (state_q == ISSUE) & ~bus.redirect_valid;
    bus.instr       = instr_q;
    bus.imm         = imm_q;
    bus.instr_pc    = instr_pc_q;
    state_dbg       = state_q;
  end

`ifndef SYNTHESIS
  a_req_addr_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.imem_req && !bus.imem_ack && !bus.redirect_valid)
      |=> (bus.imem_req && $stable(bus.imem_addr)));

  a_issue_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.instr_valid && !bus.instr_ready)
      |=> $stable({instr_q, imm_q, instr_pc_q}));
`endif

endmodule
